// File: rtl/serial_adder_hs.sv
// Multi-cycle adder/subtractor: WIDTH-bit operands summed DIGIT bits per clock
// behind valid/ready handshakes, with registered carry-out and signed overflow.
module serial_adder_hs #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             busy
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  generate
    if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("serial_adder_hs: DIGIT must be >=1 and divide WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q, res_q, res_nxt;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic             last;
  logic [DIGIT:0]   dsum;
  logic             dig_ovf;
  logic             in_ready_d, out_valid_d, busy_d;

  // One digit of ripple add; bit DIGIT is the carry into the next digit.
  assign dsum    = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};
  // Signed overflow at the digit MSB: like-signed operands, differently-signed sum.
  assign dig_ovf = (a_q[DIGIT-1] == b_q[DIGIT-1]) && (dsum[DIGIT-1] != a_q[DIGIT-1]);
  assign res_nxt = (res_q >> DIGIT) | (WIDTH'(dsum[DIGIT-1:0]) << (WIDTH - DIGIT));
  assign last    = (cnt_q == CW'(N - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (in_valid)  state_nxt = BUSY;
      BUSY:    if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Status outputs are decoded from the next state so they register alongside it.
  always_comb begin
    in_ready_d  = (state_nxt == IDLE);
    out_valid_d = (state_nxt == DONE);
    busy_d      = (state_nxt != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      carry_q   <= 1'b0;
      cnt_q     <= '0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
      out_ovf   <= 1'b0;
    end else begin
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
      busy      <= busy_d;
      unique case (state)
        IDLE: if (in_valid) begin
          a_q     <= in_a;
          b_q     <= in_sub ? ~in_b : in_b;
          carry_q <= in_sub ? 1'b1 : in_cin;
          cnt_q   <= '0;
        end
        BUSY: begin
          a_q     <= a_q >> DIGIT;
          b_q     <= b_q >> DIGIT;
          res_q   <= res_nxt;
          carry_q <= dsum[DIGIT];
          cnt_q   <= cnt_q + CW'(1);
          if (last) begin
            out_sum  <= res_nxt;
            out_cout <= dsum[DIGIT];
            out_ovf  <= dig_ovf;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
